// File: rtl/czonotope_pkg.sv
// Shared field encodings, FSM state type and section-skip helper for the CZonotope reader.
package czonotope_pkg;

    localparam logic [1:0] FIELD_C = 2'd0;
    localparam logic [1:0] FIELD_G = 2'd1;
    localparam logic [1:0] FIELD_A = 2'd2;
    localparam logic [1:0] FIELD_B = 2'd3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_C  = 3'd1,
        RD_G  = 3'd2,
        RD_A  = 3'd3,
        RD_B  = 3'd4,
        DRAIN = 3'd5
    } state_e;

    // First non-empty section strictly after cur (IDLE means "from the beginning").
    function automatic state_e next_section(input state_e cur, input logic has_c,
                                            input logic has_g, input logic has_a,
                                            input logic has_b);
        state_e nxt;
        nxt = DRAIN;
        case (cur)
            IDLE: begin
                if (has_c)      nxt = RD_C;
                else if (has_g) nxt = RD_G;
                else if (has_a) nxt = RD_A;
                else if (has_b) nxt = RD_B;
            end
            RD_C: begin
                if (has_g)      nxt = RD_G;
                else if (has_a) nxt = RD_A;
                else if (has_b) nxt = RD_B;
            end
            RD_G: begin
                if (has_a)      nxt = RD_A;
                else if (has_b) nxt = RD_B;
            end
            RD_A: begin
                if (has_b)      nxt = RD_B;
            end
            default: nxt = DRAIN;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/czono_stream_fifo.sv
// Two-entry output FIFO; read side is a registered entry selected by the read pointer.
module czono_stream_fifo #(
    parameter int unsigned WIDTH = 35
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [1:0]       count,
    output logic             valid
);

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;

    // Pointer and occupancy update; callers never write when full or read when empty.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (rd_en) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + 2'(wr_en) - 2'(rd_en);
    end

    // Storage and pointer registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign valid   = (count_q != 2'd0);

endmodule

// File: rtl/czonotope_reader.sv
// Streams one CZonotope (c, G, A, b) from synchronous-read memories onto a valid/ready port.
module czonotope_reader
    import czonotope_pkg::*;
#(
    parameter int unsigned NMAX       = 3,
    parameter int unsigned NGMAX      = 15,
    parameter int unsigned NCMAX      = 12,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic                         start,
    input  logic [$clog2(NMAX+1)-1:0]    n,
    input  logic [$clog2(NGMAX+1)-1:0]   ng,
    input  logic [$clog2(NCMAX+1)-1:0]   nc,
    output logic [$clog2(NMAX)-1:0]      c_addr,
    input  logic [DATA_WIDTH-1:0]        c_rdata,
    output logic [$clog2(NMAX)-1:0]      G_raddr,
    output logic [$clog2(NGMAX)-1:0]     G_caddr,
    input  logic [DATA_WIDTH-1:0]        G_rdata,
    output logic [$clog2(NCMAX)-1:0]     A_raddr,
    output logic [$clog2(NGMAX)-1:0]     A_caddr,
    input  logic [DATA_WIDTH-1:0]        A_rdata,
    output logic [$clog2(NCMAX)-1:0]     b_addr,
    input  logic [DATA_WIDTH-1:0]        b_rdata,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [DATA_WIDTH-1:0]        m_data,
    output logic [1:0]                   m_field,
    output logic                         m_last,
    output logic                         busy,
    output logic                         done
);

    localparam int unsigned NW  = $clog2(NMAX+1);
    localparam int unsigned GW  = $clog2(NGMAX+1);
    localparam int unsigned CW  = $clog2(NCMAX+1);
    localparam int unsigned NAW = $clog2(NMAX);
    localparam int unsigned GAW = $clog2(NGMAX);
    localparam int unsigned CAW = $clog2(NCMAX);
    localparam int unsigned RW  = (NAW > CAW) ? NAW : CAW;
    localparam int unsigned EW  = DATA_WIDTH + 3;

    state_e           state_q, state_d;
    logic [RW-1:0]    row_q, row_d;
    logic [GAW-1:0]   col_q, col_d;
    logic [NW-1:0]    n_q, n_d;
    logic [GW-1:0]    ng_q, ng_d;
    logic [CW-1:0]    nc_q, nc_d;
    logic             infl_q, infl_d;
    logic [1:0]       infl_field_q, infl_field_d;
    logic             infl_last_q, infl_last_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [NW-1:0]    n_use;
    logic [GW-1:0]    ng_use;
    logic [CW-1:0]    nc_use;
    logic             has_c, has_g, has_a, has_b;
    state_e           sec, nxt;
    logic             reading, credit_ok, row_end, sec_end;
    logic             row_last_n, row_last_c, col_last;
    logic             pop, last_c;
    logic [1:0]       fifo_count;
    logic             fifo_valid;
    logic [EW-1:0]    fifo_rd;
    logic [DATA_WIDTH-1:0] rdata_sel;

    // Dimensions come straight from the ports on the accepting cycle, from the latch afterwards.
    always_comb begin
        n_use      = (state_q == IDLE) ? n  : n_q;
        ng_use     = (state_q == IDLE) ? ng : ng_q;
        nc_use     = (state_q == IDLE) ? nc : nc_q;
        has_c      = (n_use != '0);
        has_g      = (n_use != '0) && (ng_use != '0);
        has_a      = (nc_use != '0) && (ng_use != '0);
        has_b      = (nc_use != '0);
        sec        = (state_q == IDLE) ? next_section(IDLE, has_c, has_g, has_a, has_b) : state_q;
        row_last_n = (32'(row_q) + 32'd1 == 32'(n_use));
        row_last_c = (32'(row_q) + 32'd1 == 32'(nc_use));
        col_last   = (32'(col_q) + 32'd1 == 32'(ng_use));
        pop        = fifo_valid && m_ready;
        last_c     = fifo_valid && fifo_rd[DATA_WIDTH];
        credit_ok  = (32'(fifo_count) + 32'(infl_q) - 32'(pop)) < 32'd2;
    end

    // Sequencer: issues one read per cycle while credit allows and walks the sections.
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        n_d          = n_q;
        ng_d         = ng_q;
        nc_d         = nc_q;
        infl_d       = 1'b0;
        infl_field_d = infl_field_q;
        infl_last_d  = 1'b0;
        done_d       = 1'b0;
        row_end      = 1'b0;
        sec_end      = 1'b0;
        nxt          = DRAIN;
        reading      = ((state_q == IDLE) && start) ||
                       (state_q inside {RD_C, RD_G, RD_A, RD_B});

        if ((state_q == IDLE) && start) begin
            n_d  = n;
            ng_d = ng;
            nc_d = nc;
        end

        if (reading && (sec != DRAIN) && credit_ok) begin
            infl_d = 1'b1;
            case (sec)
                RD_C: begin
                    infl_field_d = FIELD_C;
                    row_end      = row_last_n;
                    sec_end      = row_last_n;
                end
                RD_G: begin
                    infl_field_d = FIELD_G;
                    row_end      = row_last_n;
                    sec_end      = row_last_n && col_last;
                end
                RD_A: begin
                    infl_field_d = FIELD_A;
                    row_end      = row_last_c;
                    sec_end      = row_last_c && col_last;
                end
                default: begin
                    infl_field_d = FIELD_B;
                    row_end      = row_last_c;
                    sec_end      = row_last_c;
                end
            endcase
            if (sec_end) begin
                nxt         = next_section(sec, has_c, has_g, has_a, has_b);
                state_d     = nxt;
                row_d       = '0;
                col_d       = '0;
                infl_last_d = (nxt == DRAIN);
            end else if (row_end) begin
                state_d = sec;
                row_d   = '0;
                col_d   = col_q + GAW'(1);
            end else begin
                state_d = sec;
                row_d   = row_q + RW'(1);
            end
        end else if ((state_q == IDLE) && start && (sec == DRAIN)) begin
            done_d = 1'b1;
        end else if ((state_q == DRAIN) && pop && last_c) begin
            state_d = IDLE;
            done_d  = 1'b1;
        end

        busy_d = (state_d != IDLE) || done_d;
    end

    // Memory addresses for the section being read; idle sections hold 0.
    always_comb begin
        c_addr  = '0;
        G_raddr = '0;
        G_caddr = '0;
        A_raddr = '0;
        A_caddr = '0;
        b_addr  = '0;
        case (sec)
            RD_C: c_addr = NAW'(row_q);
            RD_G: begin
                G_raddr = NAW'(row_q);
                G_caddr = col_q;
            end
            RD_A: begin
                A_raddr = CAW'(row_q);
                A_caddr = col_q;
            end
            RD_B: b_addr = CAW'(row_q);
            default: ;
        endcase
    end

    // Pick the returning word by the field tag of the read in flight.
    always_comb begin
        case (infl_field_q)
            FIELD_C: rdata_sel = c_rdata;
            FIELD_G: rdata_sel = G_rdata;
            FIELD_A: rdata_sel = A_rdata;
            default: rdata_sel = b_rdata;
        endcase
    end

    // Control and status registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= IDLE;
            row_q        <= '0;
            col_q        <= '0;
            n_q          <= '0;
            ng_q         <= '0;
            nc_q         <= '0;
            infl_q       <= 1'b0;
            infl_field_q <= FIELD_C;
            infl_last_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            n_q          <= n_d;
            ng_q         <= ng_d;
            nc_q         <= nc_d;
            infl_q       <= infl_d;
            infl_field_q <= infl_field_d;
            infl_last_q  <= infl_last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    czono_stream_fifo #(
        .WIDTH (EW)
    ) u_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .wr_en   (infl_q),
        .wr_data ({infl_field_q, infl_last_q, rdata_sel}),
        .rd_en   (pop),
        .rd_data (fifo_rd),
        .count   (fifo_count),
        .valid   (fifo_valid)
    );

    assign m_valid = fifo_valid;
    assign m_data  = fifo_rd[DATA_WIDTH-1:0];
    assign m_field = fifo_rd[EW-1:EW-2];
    assign m_last  = last_c;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_czonotope_reader.sv
// Directed bench for czonotope_reader with a queue-based stream model checked every cycle.
module tb_czonotope_reader;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  field;
        logic        last;
    } beat_t;

    logic        clk_i = 1'b0;
    logic        rstn_i, start, m_ready;
    logic [1:0]  n;
    logic [3:0]  ng, nc;
    logic [1:0]  c_addr, G_raddr;
    logic [3:0]  G_caddr, A_raddr, A_caddr, b_addr;
    logic [31:0] c_rdata, G_rdata, A_rdata, b_rdata, m_data;
    logic        m_valid, m_last, busy, done;
    logic [1:0]  m_field;

    int          checks = 0;
    int          errors = 0;
    beat_t       exp_q[$];
    bit          active = 1'b0;
    bit          done_due = 1'b0;
    bit          prev_stall = 1'b0;
    bit          first_pending = 1'b0;
    beat_t       prev_beat;
    int          beat_no = 0;
    int          since_accept = 0;
    logic [31:0] cap_data [64];

    always #5 clk_i = ~clk_i;

    czonotope_reader dut (
        .clk_i   (clk_i),   .rstn_i  (rstn_i),  .start   (start),
        .n       (n),       .ng      (ng),      .nc      (nc),
        .c_addr  (c_addr),  .c_rdata (c_rdata),
        .G_raddr (G_raddr), .G_caddr (G_caddr), .G_rdata (G_rdata),
        .A_raddr (A_raddr), .A_caddr (A_caddr), .A_rdata (A_rdata),
        .b_addr  (b_addr),  .b_rdata (b_rdata),
        .m_valid (m_valid), .m_ready (m_ready), .m_data  (m_data),
        .m_field (m_field), .m_last  (m_last),  .busy    (busy),
        .done    (done)
    );

    function automatic logic [31:0] word_c(input int i);
        return 32'h0C00_0000 + 32'(i);
    endfunction
    function automatic logic [31:0] word_g(input int r, input int c);
        return 32'h1000_0000 + 32'(r * 16 + c);
    endfunction
    function automatic logic [31:0] word_a(input int r, input int c);
        return 32'h2000_0000 + 32'(r * 16 + c);
    endfunction
    function automatic logic [31:0] word_b(input int i);
        return 32'h3000_0000 + 32'(i);
    endfunction

    // Synchronous-read memories.
    always @(posedge clk_i) begin
        c_rdata <= word_c(int'(c_addr));
        G_rdata <= word_g(int'(G_raddr), int'(G_caddr));
        A_rdata <= word_a(int'(A_raddr), int'(A_caddr));
        b_rdata <= word_b(int'(b_addr));
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected beat sequence straight from the dimensions.
    task automatic build(input int dn, input int dg, input int dc);
        beat_t t;
        exp_q.delete();
        for (int i = 0; i < dn; i++) exp_q.push_back('{word_c(i), 2'd0, 1'b0});
        for (int c = 0; c < dg; c++)
            for (int r = 0; r < dn; r++) exp_q.push_back('{word_g(r, c), 2'd1, 1'b0});
        for (int c = 0; c < dg; c++)
            for (int r = 0; r < dc; r++) exp_q.push_back('{word_a(r, c), 2'd2, 1'b0});
        for (int i = 0; i < dc; i++) exp_q.push_back('{word_b(i), 2'd3, 1'b0});
        if (exp_q.size() != 0) begin
            t = exp_q[exp_q.size() - 1];
            t.last = 1'b1;
            exp_q[exp_q.size() - 1] = t;
        end
    endtask

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk_i) begin
        if (!rstn_i) begin
            check("rst_m_valid", 64'(m_valid), 64'd0);
            check("rst_m_last", 64'(m_last), 64'd0);
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_done", 64'(done), 64'd0);
            check("rst_addr", 64'({c_addr, G_raddr, G_caddr, A_raddr, A_caddr, b_addr}), 64'd0);
            exp_q.delete();
            active        = 1'b0;
            done_due      = 1'b0;
            prev_stall    = 1'b0;
            first_pending = 1'b0;
        end else begin
            since_accept++;
            check("busy", 64'(busy), 64'(active));
            check("done", 64'(done), 64'(done_due));
            if (done_due) begin
                active   = 1'b0;
                done_due = 1'b0;
            end
            if (prev_stall)
                check("stall_stable", 64'({m_valid, m_data, m_field, m_last}), 64'({1'b1, prev_beat}));
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 64'(m_valid), 64'd0);
                end else begin
                    if (first_pending) begin
                        check("first_latency", 64'(since_accept), 64'd2);
                        first_pending = 1'b0;
                    end
                    check($sformatf("beat%0d", beat_no), 64'({m_data, m_field, m_last}), 64'(exp_q[0]));
                    if (m_ready) begin
                        if (beat_no < 64) cap_data[beat_no] = m_data;
                        beat_no++;
                        if (exp_q[0].last) done_due = 1'b1;
                        void'(exp_q.pop_front());
                    end
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_beat  = '{m_data, m_field, m_last};
            if (start && !active) begin
                build(int'(n), int'(ng), int'(nc));
                active        = 1'b1;
                since_accept  = 0;
                beat_no       = 0;
                first_pending = (exp_q.size() != 0);
                if (exp_q.size() == 0) done_due = 1'b1;
            end
        end
    end

    // mode 0: ready high; 1: random ready; 2: ready low for 5 cycles once data is due.
    task automatic run(input int dn, input int dg, input int dc, input int mode,
                       input int restart_at, input int reset_at);
        bit restarted = 1'b0;
        m_ready = 1'b1;
        @(posedge clk_i); #1;
        n = 2'(dn); ng = 4'(dg); nc = 4'(dc); start = 1'b1;
        @(posedge clk_i); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 400 && active; cyc++) begin
            case (mode)
                1:       m_ready = 1'($urandom_range(0, 1));
                2:       m_ready = !(cyc >= 1 && cyc < 6);
                default: m_ready = 1'b1;
            endcase
            if (restart_at >= 0 && !restarted && beat_no == restart_at) begin
                start     = 1'b1;
                restarted = 1'b1;
            end
            if (reset_at >= 0 && beat_no == reset_at) begin
                rstn_i = 1'b0;
                repeat (2) @(posedge clk_i);
                #1 rstn_i = 1'b1;
                break;
            end
            @(posedge clk_i); #1;
            start = 1'b0;
        end
        check("stream_timeout", 64'(active), 64'd0);
        m_ready = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    initial begin
        rstn_i = 1'b0; start = 1'b0; m_ready = 1'b1;
        n = '0; ng = '0; nc = '0;
        repeat (3) @(posedge clk_i);
        #1 rstn_i = 1'b1;

        run(3, 2, 1, 0, -1, -1);
        check("t1_count", 64'(beat_no), 64'd12);
        check("t1_c0", 64'(cap_data[0]), 64'h0C00_0000);
        check("t1_g00", 64'(cap_data[3]), 64'h1000_0000);
        check("t1_g10", 64'(cap_data[4]), 64'h1000_0010);
        check("t1_a01", 64'(cap_data[10]), 64'h2000_0001);
        check("t1_b0", 64'(cap_data[11]), 64'h3000_0000);

        run(3, 2, 1, 1, -1, -1);
        check("t2_count", 64'(beat_no), 64'd12);
        run(3, 2, 1, 2, -1, -1);
        check("t3_count", 64'(beat_no), 64'd12);

        run(2, 3, 0, 0, -1, -1);
        check("t4_count", 64'(beat_no), 64'd8);
        check("t4_c1", 64'(cap_data[1]), 64'h0C00_0001);
        check("t4_g12", 64'(cap_data[7]), 64'h1000_0012);

        run(0, 2, 2, 0, -1, -1);
        check("t5_count", 64'(beat_no), 64'd6);
        check("t5_a00", 64'(cap_data[0]), 64'h2000_0000);

        run(0, 0, 0, 0, -1, -1);
        check("t6_count", 64'(beat_no), 64'd0);

        run(3, 2, 1, 0, 3, -1);
        check("t7_count", 64'(beat_no), 64'd12);

        run(3, 2, 1, 0, -1, 4);
        repeat (4) @(posedge clk_i);
        #1;
        run(3, 2, 1, 1, -1, -1);
        check("t8_count", 64'(beat_no), 64'd12);
        check("t8_c0", 64'(cap_data[0]), 64'h0C00_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
